// File: rtl/inst_cache_dm_if.sv
// Fetch-side lookup bus for the direct-mapped instruction cache.
// Latency: hit answered in the same cycle as the request; a miss holds hit low for the fill penalty.
// Backpressure: none; the requester keeps enable/pc asserted until hit rises.
// Signals: enable/pc (requester -> cache), hit/inst (cache -> requester).
interface inst_cache_dm_if #(
    parameter int WORD_SIZE = 32
);
    logic                 enable;
    logic [WORD_SIZE-1:0] pc;
    logic                 hit;
    logic [WORD_SIZE-1:0] inst;

    modport master (
        output enable,
        output pc,
        input  hit,
        input  inst
    );

    modport slave (
        input  enable,
        input  pc,
        output hit,
        output inst
    );
endinterface

// File: rtl/inst_cache_dm.sv
// Direct-mapped read-only instruction cache (one word per line) backed by an internal ROM.
// Latency: hit is combinational (same cycle); a miss costs MEM_STALL cycles before the line hits.
// Backpressure: hit stays low while a fill is in flight; lookups resume only once the FSM is idle.
// Ports: clk, reset (sync, active-high), bus (slave: enable/pc in, hit/inst out).
module inst_cache_dm #(
    parameter int    WORD_SIZE = 32,
    parameter int    LINES     = 16,
    parameter int    MEM_DEPTH = 1024,
    parameter int    MEM_STALL = 5,
    parameter string INIT_FILE = "inst.mem"
) (
    input  logic            clk,
    input  logic            reset,
    inst_cache_dm_if.slave  bus
);
    localparam int IDX_W  = $clog2(LINES);
    localparam int ADDR_W = $clog2(MEM_DEPTH);
    localparam int TAG_W  = ADDR_W - IDX_W;
    localparam int CNT_W  = $clog2(MEM_STALL);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // Line storage; only valid bits need a reset, tag/data are qualified by them.
    logic [LINES-1:0]     valid;
    logic [TAG_W-1:0]     tag_mem  [LINES];
    logic [WORD_SIZE-1:0] data_mem [LINES];

    // Backing store, contents fixed after elaboration.
    logic [WORD_SIZE-1:0] rom [MEM_DEPTH];

    logic [ADDR_W-1:0]    miss_addr;
    logic [CNT_W-1:0]     cnt;
    logic [WORD_SIZE-1:0] inst_q;

    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic [IDX_W-1:0]     miss_idx;
    logic [TAG_W-1:0]     miss_tag;
    logic                 lookup_hit;
    logic                 miss_start;
    logic                 fill_done;
    logic                 hit_w;
    logic [WORD_SIZE-1:0] inst_w;

    // pc bits above the ROM address range alias onto the same words.
    wire unused_pc_hi = &{1'b0, bus.pc[WORD_SIZE-1:ADDR_W]};

    assign idx      = bus.pc[IDX_W-1:0];
    assign tag      = bus.pc[ADDR_W-1:IDX_W];
    assign miss_idx = miss_addr[IDX_W-1:0];
    assign miss_tag = miss_addr[ADDR_W-1:IDX_W];

    // Lookups are only honoured in IDLE, so a miss can never coincide with a fill.
    assign lookup_hit = bus.enable && valid[idx] && (tag_mem[idx] == tag) && (state == IDLE);

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) begin
            rom[i] = '0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.enable && !lookup_hit) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        miss_start = 1'b0;
        fill_done  = 1'b0;
        hit_w      = 1'b0;
        inst_w     = inst_q;
        case (state)
            IDLE: begin
                hit_w      = lookup_hit && !reset;
                miss_start = bus.enable && !lookup_hit;
                if (hit_w) begin
                    inst_w = data_mem[idx];
                end
            end
            FILL: begin
                fill_done = (cnt == CNT_W'(1));
            end
            default: ;
        endcase
    end

    assign bus.hit  = hit_w;
    assign bus.inst = inst_w;

    // Miss bookkeeping. The counter is loaded with MEM_STALL-1 on the first miss
    // cycle and the line is written on the edge where it would pass 1, giving a
    // MEM_STALL-cycle miss window. Reset drops any fill in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid     <= '0;
            cnt       <= '0;
            miss_addr <= '0;
            inst_q    <= '0;
        end else begin
            if (miss_start) begin
                miss_addr <= bus.pc[ADDR_W-1:0];
                cnt       <= CNT_W'(MEM_STALL - 1);
            end else if (state == FILL) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (fill_done) begin
                valid[miss_idx] <= 1'b1;
                inst_q          <= rom[miss_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && fill_done) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= rom[miss_addr];
        end
    end
endmodule

// File: tb/tb_inst_cache_dm.sv
module tb_inst_cache_dm;
    localparam int W = 32;
    localparam int L = 16;
    localparam int D = 1024;
    localparam int S = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    inst_cache_dm_if #(.WORD_SIZE(W)) bus ();

    inst_cache_dm #(
        .WORD_SIZE(W),
        .LINES    (L),
        .MEM_DEPTH(D),
        .MEM_STALL(S),
        .INIT_FILE("")
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: ROM image plus a line table; a miss seen in cycle c makes the
    // line readable from cycle c+S on, and nothing is looked up in between.
    logic [31:0] mrom  [D];
    bit          mvalid[L];
    int          mtag  [L];
    logic [31:0] mdata [L];
    bit          busy = 0;
    int          busy_until = 0;
    int          faddr = 0;
    int          cyc = 0;

    always @(negedge clk) begin
        int  a;
        int  li;
        bit  eh;
        a  = int'(bus.pc[9:0]);
        li = a % L;
        eh = !reset && !busy && bus.enable && mvalid[li] && (mtag[li] == a / L);
        check("model_hit", {31'b0, bus.hit}, {31'b0, eh});
        if (eh) begin
            check("model_inst", bus.inst, mdata[li]);
        end
        if (reset) begin
            for (int i = 0; i < L; i++) mvalid[i] = 0;
            busy = 0;
        end else if (busy) begin
            if (cyc == busy_until) begin
                mvalid[faddr % L] = 1;
                mtag[faddr % L]   = faddr / L;
                mdata[faddr % L]  = mrom[faddr];
                busy = 0;
            end
        end else if (bus.enable && !eh) begin
            busy       = 1;
            busy_until = cyc + S - 1;
            faddr      = a;
        end
        cyc++;
    end

    task automatic drive(input logic r, input logic en, input logic [31:0] p);
        @(posedge clk);
        #1;
        reset      = r;
        bus.enable = en;
        bus.pc     = p;
    endtask

    // Hold pc with enable high until hit, counting the cycles spent waiting.
    task automatic miss_run(input logic [31:0] p, input int exp_stalls,
                            input logic [31:0] exp_inst, input string name);
        int st = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 1'b1, p);
            @(negedge clk);
            if (bus.hit) break;
            st++;
        end
        check({name, "_stalls"}, st, exp_stalls);
        check({name, "_inst"}, bus.inst, exp_inst);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] idle_pcs [4];
        for (int i = 0; i < D; i++) mrom[i] = 32'h0;
        for (int i = 0; i < L; i++) begin
            mvalid[i] = 0;
            mtag[i]   = 0;
            mdata[i]  = 32'h0;
        end
        mrom[0]  = 32'h1000_0001;
        mrom[1]  = 32'hCAFE_0001;
        mrom[2]  = 32'h2222_0002;
        mrom[3]  = 32'h3333_0003;
        mrom[4]  = 32'h4444_0004;
        mrom[5]  = 32'h5555_0005;
        mrom[16] = 32'hAAAA_5555;
        reset      = 1'b1;
        bus.enable = 1'b0;
        bus.pc     = 32'h0;
        #1;
        for (int i = 0; i < D; i++) dut.rom[i] = mrom[i];

        // One reset cycle, then idle.
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("reset_hit", {31'b0, bus.hit}, 32'h0);
        check("reset_inst", bus.inst, 32'h0);

        // Cold miss then steady hits.
        miss_run(32'd0, 5, 32'h1000_0001, "cold0");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 32'd0);
            @(negedge clk);
            check("hold0_hit", {31'b0, bus.hit}, 32'h1);
            check("hold0_inst", bus.inst, 32'h1000_0001);
        end

        // Conflict eviction on index 0.
        miss_run(32'd16, 5, 32'hAAAA_5555, "conflict16");
        miss_run(32'd0, 5, 32'h1000_0001, "evict0");

        // Disabled lookups never hit, even for a resident line.
        idle_pcs = '{32'd3, 32'd0, 32'd16, 32'd3};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, idle_pcs[i]);
            @(negedge clk);
            check("disabled_hit", {31'b0, bus.hit}, 32'h0);
        end
        miss_run(32'd3, 5, 32'h3333_0003, "en_rise3");

        // Reset in the third miss cycle aborts the fill.
        drive(1'b0, 1'b1, 32'd2);
        drive(1'b0, 1'b1, 32'd2);
        drive(1'b1, 1'b1, 32'd2);
        drive(1'b0, 1'b0, 32'd2);
        @(negedge clk);
        check("abort_hit", {31'b0, bus.hit}, 32'h0);
        check("abort_inst", bus.inst, 32'h0);
        miss_run(32'd2, 5, 32'h2222_0002, "after_abort2");

        // Addresses wrap modulo the ROM depth.
        miss_run(32'd1025, 5, 32'hCAFE_0001, "wrap1025");
        miss_run(32'd1, 0, 32'hCAFE_0001, "alias1");

        // pc change and enable drop mid-fill: the latched line still lands.
        drive(1'b0, 1'b1, 32'd4);
        drive(1'b0, 1'b0, 32'd4);
        drive(1'b0, 1'b1, 32'd5);
        miss_run(32'd5, 7, 32'h5555_0005, "pc_change5");
        miss_run(32'd4, 0, 32'h4444_0004, "fill_kept4");

        drive(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
